// File: rtl/ex_wb_reg.sv
// EX/WB pipeline register: captures the execute-stage result, pre-selects the
// forwarding value and counts valid instructions that reach write-back.
module ex_wb_reg #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_ALUResult,
  input  logic [DATA_W-1:0] ex_imm,
  input  logic              ex_valueToReg,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_RegWrite,
  input  logic              stall,
  input  logic              flush,
  output logic              wb_valid,
  output logic [DATA_W-1:0] ALUResult,
  output logic [DATA_W-1:0] imm,
  output logic              valueToReg,
  output logic [REG_AW-1:0] rd,
  output logic              RegWrite,
  output logic              fwd_valid,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  load_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              r_valid;
  logic [DATA_W-1:0] r_alu;
  logic [DATA_W-1:0] r_imm;
  logic              r_vtr;
  logic [REG_AW-1:0] r_rd;
  logic              r_regwrite;
  logic              r_wr_en;
  logic [DATA_W-1:0] r_fwd_data;
  logic [CNT_W-1:0]  r_count;

  logic [DATA_W-1:0] w_fwd_sel;
  logic [CNT_W-1:0]  w_count_next;

  // Forwarding value and saturating count increment, computed ahead of the edge.
  always_comb begin
    w_fwd_sel    = ex_valueToReg ? ex_ALUResult : ex_imm;
    w_count_next = r_count;
    if (ex_valid && (r_count != CNT_MAX)) begin
      w_count_next = r_count + CNT_ONE;
    end else begin
      w_count_next = r_count;
    end
  end

  // Stage state; priority is reset, then flush, then stall, then load.
  // The write enable is stored pre-qualified by ex_valid so that every output
  // comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_alu      <= '0;
      r_imm      <= '0;
      r_vtr      <= 1'b0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_wr_en    <= 1'b0;
      r_fwd_data <= '0;
      r_count    <= '0;
    end else if (flush) begin
      r_valid    <= 1'b0;
      r_alu      <= '0;
      r_imm      <= '0;
      r_vtr      <= 1'b0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_wr_en    <= 1'b0;
      r_fwd_data <= '0;
    end else if (stall) begin
      r_valid    <= r_valid;
      r_wr_en    <= r_wr_en;
    end else begin
      r_valid    <= ex_valid;
      r_alu      <= ex_ALUResult;
      r_imm      <= ex_imm;
      r_vtr      <= ex_valueToReg;
      r_rd       <= ex_rd;
      r_regwrite <= ex_RegWrite;
      r_wr_en    <= ex_RegWrite & ex_valid;
      r_fwd_data <= w_fwd_sel;
      r_count    <= w_count_next;
    end
  end

  assign wb_valid   = r_valid;
  assign ALUResult  = r_alu;
  assign imm        = r_imm;
  assign valueToReg = r_vtr;
  assign rd         = r_rd;
  assign RegWrite   = r_wr_en;
  assign fwd_valid  = r_wr_en;
  assign fwd_data   = r_fwd_data;
  assign load_count = r_count;

  // r_regwrite mirrors the raw stored field; the qualified copy drives outputs.
  logic w_unused;
  assign w_unused = r_regwrite;

endmodule

// File: tb/tb_ex_wb_reg.sv
// Directed self-checking bench for ex_wb_reg; a second instance with a 4-bit
// counter shares the stimulus to exercise saturation.
module tb_ex_wb_reg;

  logic       clk;
  logic       reset;
  logic       ex_valid;
  logic [7:0] ex_ALUResult;
  logic [7:0] ex_imm;
  logic       ex_valueToReg;
  logic [2:0] ex_rd;
  logic       ex_RegWrite;
  logic       stall;
  logic       flush;

  logic        wb_valid, valueToReg, RegWrite, fwd_valid;
  logic [7:0]  ALUResult, imm, fwd_data;
  logic [2:0]  rd;
  logic [15:0] load_count;

  logic       s_wb_valid, s_valueToReg, s_RegWrite, s_fwd_valid;
  logic [7:0] s_ALUResult, s_imm, s_fwd_data;
  logic [2:0] s_rd;
  logic [3:0] s_load_count;

  int n_pass;
  int n_total;

  ex_wb_reg dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ALUResult(ex_ALUResult),
    .ex_imm(ex_imm), .ex_valueToReg(ex_valueToReg), .ex_rd(ex_rd),
    .ex_RegWrite(ex_RegWrite), .stall(stall), .flush(flush),
    .wb_valid(wb_valid), .ALUResult(ALUResult), .imm(imm),
    .valueToReg(valueToReg), .rd(rd), .RegWrite(RegWrite),
    .fwd_valid(fwd_valid), .fwd_data(fwd_data), .load_count(load_count)
  );

  ex_wb_reg #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ALUResult(ex_ALUResult),
    .ex_imm(ex_imm), .ex_valueToReg(ex_valueToReg), .ex_rd(ex_rd),
    .ex_RegWrite(ex_RegWrite), .stall(stall), .flush(flush),
    .wb_valid(s_wb_valid), .ALUResult(s_ALUResult), .imm(s_imm),
    .valueToReg(s_valueToReg), .rd(s_rd), .RegWrite(s_RegWrite),
    .fwd_valid(s_fwd_valid), .fwd_data(s_fwd_data), .load_count(s_load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] alu, input logic [7:0] im,
                       input logic vtr, input logic [2:0] r, input logic rw);
    ex_valid      = v;
    ex_ALUResult  = alu;
    ex_imm        = im;
    ex_valueToReg = vtr;
    ex_rd         = r;
    ex_RegWrite   = rw;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_total++;
    if ({wb_valid, RegWrite, fwd_valid, valueToReg} !== 4'b0000)
      $display("FAIL reset_flags got %b want 0000", {wb_valid, RegWrite, fwd_valid, valueToReg});
    else n_pass++;
    n_total++;
    if ({ALUResult, imm, fwd_data, rd} !== 27'd0)
      $display("FAIL reset_data got %h %h %h %h want 0", ALUResult, imm, fwd_data, rd);
    else n_pass++;
    n_total++;
    if (load_count !== 16'd0) $display("FAIL reset_count got %0d want 0", load_count);
    else n_pass++;
  endtask

  task automatic test_basic_load();
    drive(1'b1, 8'h3C, 8'h05, 1'b1, 3'd3, 1'b1);
    tick();
    n_total++;
    if ({wb_valid, RegWrite, fwd_valid, valueToReg} !== 4'b1111)
      $display("FAIL load_flags got %b want 1111", {wb_valid, RegWrite, fwd_valid, valueToReg});
    else n_pass++;
    n_total++;
    if (rd !== 3'd3) $display("FAIL load_rd got %0d want 3", rd);
    else n_pass++;
    n_total++;
    if (fwd_data !== 8'h3C) $display("FAIL load_fwd got %h want 3c", fwd_data);
    else n_pass++;
    n_total++;
    if ({ALUResult, imm} !== 16'h3C05) $display("FAIL load_fields got %h %h want 3c 05", ALUResult, imm);
    else n_pass++;
    n_total++;
    if (load_count !== 16'd1) $display("FAIL load_count got %0d want 1", load_count);
    else n_pass++;
  endtask

  task automatic test_imm_select();
    drive(1'b1, 8'h3C, 8'h05, 1'b0, 3'd3, 1'b1);
    tick();
    n_total++;
    if (fwd_data !== 8'h05) $display("FAIL imm_fwd got %h want 05", fwd_data);
    else n_pass++;
    n_total++;
    if ({ALUResult, valueToReg} !== {8'h3C, 1'b0})
      $display("FAIL imm_alu got %h %b want 3c 0", ALUResult, valueToReg);
    else n_pass++;
    n_total++;
    if (load_count !== 16'd2) $display("FAIL imm_count got %0d want 2", load_count);
    else n_pass++;
  endtask

  task automatic test_stall();
    drive(1'b1, 8'hA1, 8'hB2, 1'b1, 3'd5, 1'b1);
    tick();
    stall = 1'b1;
    drive(1'b1, 8'h11, 8'h22, 1'b0, 3'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if ({wb_valid, RegWrite, ALUResult, fwd_data, rd} !== {1'b1, 1'b1, 8'hA1, 8'hA1, 3'd5})
        $display("FAIL stall_hold[%0d] got %b %b %h %h %0d want 1 1 a1 a1 5",
                 i, wb_valid, RegWrite, ALUResult, fwd_data, rd);
      else n_pass++;
      n_total++;
      if (load_count !== 16'd3) $display("FAIL stall_count[%0d] got %0d want 3", i, load_count);
      else n_pass++;
    end
    stall = 1'b0;
    tick();
    n_total++;
    if ({ALUResult, fwd_data, RegWrite, load_count} !== {8'h11, 8'h22, 1'b0, 16'd4})
      $display("FAIL stall_release got %h %h %b %0d want 11 22 0 4", ALUResult, fwd_data, RegWrite, load_count);
    else n_pass++;
  endtask

  task automatic test_flush_stall();
    drive(1'b1, 8'h99, 8'h88, 1'b1, 3'd7, 1'b1);
    stall = 1'b1;
    flush = 1'b1;
    tick();
    stall = 1'b0;
    flush = 1'b0;
    n_total++;
    if ({wb_valid, RegWrite, fwd_valid} !== 3'b000)
      $display("FAIL flush_flags got %b want 000", {wb_valid, RegWrite, fwd_valid});
    else n_pass++;
    n_total++;
    if ({ALUResult, imm, fwd_data, rd, valueToReg} !== 28'd0)
      $display("FAIL flush_data got %h %h %h %0d %b want 0", ALUResult, imm, fwd_data, rd, valueToReg);
    else n_pass++;
    n_total++;
    if (load_count !== 16'd4) $display("FAIL flush_count got %0d want 4", load_count);
    else n_pass++;
  endtask

  task automatic test_bubble();
    drive(1'b0, 8'h77, 8'h66, 1'b1, 3'd2, 1'b1);
    tick();
    n_total++;
    if ({wb_valid, RegWrite, fwd_valid} !== 3'b000)
      $display("FAIL bubble_flags got %b want 000", {wb_valid, RegWrite, fwd_valid});
    else n_pass++;
    n_total++;
    if ({ALUResult, fwd_data, load_count} !== {8'h77, 8'h77, 16'd4})
      $display("FAIL bubble_fields got %h %h %0d want 77 77 4", ALUResult, fwd_data, load_count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] alu_v [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
    logic [7:0] imm_v [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic       vtr_v [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] exp_fwd [4] = '{8'h10, 8'h02, 8'h03, 8'h40};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, alu_v[i], imm_v[i], vtr_v[i], 3'(i), 1'b1);
      tick();
      n_total++;
      if ({fwd_data, rd, load_count} !== {exp_fwd[i], 3'(i), 16'(5 + i)})
        $display("FAIL b2b[%0d] got %h %0d %0d want %h %0d %0d",
                 i, fwd_data, rd, load_count, exp_fwd[i], i, 5 + i);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 8'h55, 8'h00, 1'b1, 3'd2, 1'b1);
    tick();
    stall = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_total++;
    if ({wb_valid, RegWrite, ALUResult, load_count} !== {1'b0, 1'b0, 8'h00, 16'd0})
      $display("FAIL rst_stall got %b %b %h %0d want 0 0 00 0", wb_valid, RegWrite, ALUResult, load_count);
    else n_pass++;
    stall = 1'b0;
    drive(1'b1, 8'h66, 8'h01, 1'b1, 3'd4, 1'b1);
    tick();
    n_total++;
    if ({wb_valid, fwd_valid, fwd_data, load_count} !== {1'b1, 1'b1, 8'h66, 16'd1})
      $display("FAIL rst_resume got %b %b %h %0d want 1 1 66 1", wb_valid, fwd_valid, fwd_data, load_count);
    else n_pass++;
  endtask

  task automatic test_saturation_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b1, 8'hC3, 8'h3C, 1'b0, 3'd6, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) begin
        n_total++;
        if (s_load_count !== 4'hE) $display("FAIL sat_14 got %h want e", s_load_count);
        else n_pass++;
      end
    end
    n_total++;
    if (s_load_count !== 4'hF) $display("FAIL sat_20 got %h want f", s_load_count);
    else n_pass++;
    n_total++;
    if (load_count !== 16'd20) $display("FAIL wide_20 got %0d want 20", load_count);
    else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_total++;
    if ({s_wb_valid, s_RegWrite, s_fwd_valid, s_valueToReg, s_ALUResult, s_imm, s_fwd_data, s_rd, s_load_count} !== 35'd0)
      $display("FAIL sat_reset got %b %b %b %b %h %h %h %0d %h want all 0",
               s_wb_valid, s_RegWrite, s_fwd_valid, s_valueToReg, s_ALUResult, s_imm, s_fwd_data, s_rd, s_load_count);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    stall   = 1'b0;
    flush   = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    test_reset();
    test_basic_load();
    test_imm_select();
    test_stall();
    test_flush_stall();
    test_bubble();
    test_back_to_back();
    test_reset_mid_stall();
    test_saturation_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ex_wb_reg.md
EX_WB_REG -- requirements
Module: ex_wb_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 8, datapath width.
REQ-002 SHALL have parameter REG_AW, default 3, destination register address width.
REQ-003 SHALL have parameter CNT_W, default 16, width of the loaded-instruction counter.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port ex_valid  input  1  execute stage presents a valid instruction.
REQ-007 SHALL have port ex_ALUResult  input  DATA_W  ALU result from execute.
REQ-008 SHALL have port ex_imm  input  DATA_W  immediate from execute.
REQ-009 SHALL have port ex_valueToReg  input  1  write-back select: 1 = ALU result, 0 = immediate.
REQ-010 SHALL have port ex_rd  input  REG_AW  destination register.
REQ-011 SHALL have port ex_RegWrite  input  1  instruction writes the register file.
REQ-012 SHALL have port stall  input  1  hold stage contents.
REQ-013 SHALL have port flush  input  1  kill the incoming instruction; insert a bubble.
REQ-014 SHALL have port wb_valid  output  1  write-back stage holds a valid instruction.
REQ-015 SHALL have port ALUResult  output  DATA_W  registered ALU result to the write-back mux.
REQ-016 SHALL have port imm  output  DATA_W  registered immediate to the write-back mux.
REQ-017 SHALL have port valueToReg  output  1  registered write-back select.
REQ-018 SHALL have port rd  output  REG_AW  registered destination register.
REQ-019 SHALL have port RegWrite  output  1  register-file write enable, equal to the stored RegWrite AND wb_valid.
REQ-020 SHALL have port fwd_valid  output  1  forwarding source is valid, equal to wb_valid AND the stored RegWrite.
REQ-021 SHALL have port fwd_data  output  DATA_W  pre-selected write-back value for forwarding.
REQ-022 SHALL have port load_count  output  CNT_W  count of valid instructions loaded.

Function
REQ-023 SHALL apply per-edge priority: reset > flush > stall > load.
REQ-024 SHALL load when reset=0, flush=0, stall=0: all stored fields <= ex_* inputs and wb_valid <= ex_valid; outputs reflect the inputs one cycle later.
REQ-025 SHALL, on load, register fwd_data <= ex_valueToReg ? ex_ALUResult : ex_imm, so fwd_data never has a combinational path from ex_* inputs.
REQ-026 SHALL, on stall=1 with flush=0, hold every stored field, wb_valid, fwd_data and load_count unchanged.
REQ-027 SHALL, on flush=1, set wb_valid to 0, stored RegWrite to 0, and all data, rd and valueToReg fields to 0, regardless of stall and ex_valid.
REQ-028 SHALL register all fields on load even when ex_valid=0, but force RegWrite and fwd_valid to 0 while wb_valid=0.
REQ-029 SHALL increment load_count by 1 on each load with ex_valid=1.
REQ-030 SHALL saturate load_count at 2^CNT_W-1 and not wrap.
REQ-031 SHALL not change load_count on a flush or a stall.
REQ-032 SHALL have no combinational path from any input to any output.

Reset
REQ-033 SHALL, with reset=1 at a rising clk edge, set wb_valid, RegWrite, fwd_valid, valueToReg to 0, ALUResult, imm, fwd_data to 0, rd to 0 and load_count to 0.
REQ-034 SHALL, on reset asserted mid-stall or mid-flush, discard the held instruction; the first load after reset deasserts proceeds normally.
REQ-035 SHALL leave outputs unchanged by reset between clock edges.

Verification
REQ-036 SHALL check basic load: ex_valid=1, ALU=0x3C, imm=0x05, valueToReg=1, rd=3, RegWrite=1 -> next cycle wb_valid=1, RegWrite=1, rd=3, fwd_data=0x3C, load_count=1.
REQ-037 SHALL check immediate select: same stimulus with valueToReg=0 -> fwd_data=0x05, ALUResult=0x3C still presented.
REQ-038 SHALL check stall: load A, then stall=1 for 3 cycles with new ex_* values -> outputs stay A, load_count unchanged.
REQ-039 SHALL check flush and stall together: stall=1 and flush=1 with a valid ex instruction -> wb_valid=0, RegWrite=0, fwd_valid=0, load_count unchanged.
REQ-040 SHALL check bubble: ex_valid=0, ex_RegWrite=1 -> wb_valid=0, RegWrite=0, fwd_valid=0, count unchanged.
REQ-041 SHALL check saturation and reset: CNT_W=4 with 20 valid loads -> load_count=0xF; reset=1 -> all outputs 0 on the next edge.
